// File: rtl/alu_issue_ctrl.sv
// Issue sequencer feeding the ALU decoder: holds one op for its fixed latency.
// Optional divide-by-zero short-circuit enabled by ALU_DIV_ZERO_CHECK_EN.
module alu_issue_ctrl #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_opcode,
    input  logic [WIDTH-1:0] instr_a,
    input  logic [WIDTH-1:0] instr_b,
    output logic [2:0]       opcode,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             op_active,
    output logic             unit_start,
    input  logic [WIDTH-1:0] unit_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       opc_q, opc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             start_q, start_d;
`ifdef ALU_DIV_ZERO_CHECK_EN
    logic             dz_q, dz_d;
    logic             err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opc_q   <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
`ifdef ALU_DIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            start_q <= start_d;
`ifdef ALU_DIV_ZERO_CHECK_EN
            dz_q    <= dz_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        start_d = 1'b0;
`ifdef ALU_DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    opc_d   = instr_opcode;
                    a_d     = instr_a;
                    b_d     = instr_b;
                    start_d = 1'b1;
                    state_d = EXEC;
                    if (instr_opcode == OP_MUL) begin
                        cnt_d = CW'(MUL_CYCLES - 1);
                    end else if (instr_opcode == OP_DIV) begin
                        cnt_d = CW'(DIV_CYCLES - 1);
                    end else begin
                        cnt_d = '0;
                    end
`ifdef ALU_DIV_ZERO_CHECK_EN
                    dz_d = 1'b0;
                    // Divide by zero never wakes the divider; answer in one cycle.
                    if (instr_opcode == OP_DIV && instr_b == '0) begin
                        dz_d    = 1'b1;
                        cnt_d   = '0;
                        start_d = 1'b0;
                    end
`endif
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = unit_result;
                    state_d = DONE;
`ifdef ALU_DIV_ZERO_CHECK_EN
                    err_d = dz_q;
                    if (dz_q) begin
                        res_d = '1;
                    end
`endif
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_ready = (state_q == IDLE);
    assign op_active   = (state_q == EXEC);
    assign res_valid   = (state_q == DONE);
    assign unit_start  = start_q;
    assign opcode      = opc_q;
    assign operand_a   = a_q;
    assign operand_b   = b_q;
    assign res_data    = res_q;
`ifdef ALU_DIV_ZERO_CHECK_EN
    assign res_err     = err_q;
`else
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed ops, timing and reset checks.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_opcode;
    logic [7:0] instr_a;
    logic [7:0] instr_b;
    logic [2:0] opcode;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       op_active;
    logic       unit_start;
    logic [7:0] unit_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb[$];
    logic [8:0] mon_e;

    alu_issue_ctrl #(
        .WIDTH(8),
        .MUL_CYCLES(4),
        .DIV_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_opcode(instr_opcode),
        .instr_a(instr_a),
        .instr_b(instr_b),
        .opcode(opcode),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .op_active(op_active),
        .unit_start(unit_start),
        .unit_result(unit_result),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Handshake at the coming edge: pop and compare the result.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", {24'd0, res_data}, {24'd0, mon_e[7:0]});
                check("res_err", {31'd0, res_err}, {31'd0, mon_e[8]});
            end
        end
    end

    task automatic check_reset();
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_opcode", {29'd0, opcode}, 32'd0);
        check("rst_operand_a", {24'd0, operand_a}, 32'd0);
        check("rst_operand_b", {24'd0, operand_b}, 32'd0);
        check("rst_op_active", {31'd0, op_active}, 32'd0);
        check("rst_unit_start", {31'd0, unit_start}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
    endtask

    // Issue one op; during EXEC/DONE drive a different, ignored instruction.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] res,
                          input logic [8:0] exp, input int n_exp,
                          input logic exp_start, input int hold);
        int n;
        unit_result  = res;
        sb.push_back(exp);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_a      = a;
        instr_b      = b;
        res_ready    = (hold == 0);
        check("accept_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        instr_opcode = ~op;
        instr_a      = ~a;
        instr_b      = ~b;
        check("operand_a", {24'd0, operand_a}, {24'd0, a});
        check("operand_b", {24'd0, operand_b}, {24'd0, b});
        n = 0;
        while (op_active && n < 40) begin
            check("unit_start", {31'd0, unit_start},
                  {31'd0, (n == 0) ? exp_start : 1'b0});
            check("exec_opcode", {29'd0, opcode}, {29'd0, op});
            check("exec_ready", {31'd0, instr_ready}, 32'd0);
            n++;
            @(posedge clk); #1;
        end
        check("exec_len", n, n_exp);
        check("res_valid_rise", {31'd0, res_valid}, 32'd1);
        unit_result = ~res;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_ready", {31'd0, instr_ready}, 32'd0);
            check("hold_data", {24'd0, res_data}, {24'd0, exp[7:0]});
            check("hold_err", {31'd0, res_err}, {31'd0, exp[8]});
            @(posedge clk); #1;
        end
        check("done_ready", {31'd0, instr_ready}, 32'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("idle_ready", {31'd0, instr_ready}, 32'd1);
        check("idle_valid", {31'd0, res_valid}, 32'd0);
        check("idle_opcode", {29'd0, opcode}, {29'd0, op});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_opcode = 3'b000;
        instr_a      = 8'd0;
        instr_b      = 8'd0;
        unit_result  = 8'd0;
        res_ready    = 1'b0;
        #1;
        check_reset();
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset();

        run_op(3'b000, 8'd3, 8'd5, 8'd8, {1'b0, 8'd8}, 1, 1'b1, 0);
        run_op(3'b010, 8'd6, 8'd7, 8'd42, {1'b0, 8'd42}, 4, 1'b1, 0);
        run_op(3'b111, 8'd100, 8'd7, 8'd14, {1'b0, 8'd14}, 8, 1'b1, 5);
        run_op(3'b101, 8'hF0, 8'h0F, 8'hFF, {1'b0, 8'hFF}, 1, 1'b1, 2);

        // Reset mid-divide: result discarded.
        instr_valid  = 1'b1;
        instr_opcode = 3'b111;
        instr_a      = 8'd50;
        instr_b      = 8'd5;
        unit_result  = 8'd10;
        res_ready    = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_active", {31'd0, op_active}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
            check("post_rst_valid", {31'd0, res_valid}, 32'd0);
        end

`ifdef ALU_DIV_ZERO_CHECK_EN
        run_op(3'b111, 8'd9, 8'd0, 8'd55, {1'b1, 8'hFF}, 1, 1'b0, 1);
`else
        run_op(3'b111, 8'd9, 8'd0, 8'd55, {1'b0, 8'd55}, 8, 1'b1, 1);
`endif
        run_op(3'b001, 8'd1, 8'd2, 8'd3, {1'b0, 8'd3}, 1, 1'b1, 0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
